mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4-to-1 data mux. Four requesters each present a data word and a request line. The block grants one at a time, steers the mux select, and presents the selected word downstream under a valid/ready handshake. It sits between the requesting sources and the single downstream consumer of the mux output.

## Interface
Parameters:
- `WIDTH`, 3: data width of each input and of `y`.
- `HOLD_MAX`, 4: maximum transfers per grant; used only with `ARB_HOLD_LIMIT_EN`. Legal range 1..15.

Ports:
- `clk`  in  1: the only clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: global enable; low forces release and blocks new grants.
- `req`  in  4: request lines; bit i belongs to input i (0=`a`, 1=`b`, 2=`c`, 3=`d`).
- `a`, `b`, `c`, `d`  in  WIDTH each: requester data words.
- `ready`  in  1: downstream accepts `y` this cycle.
- `gnt`  out  4: registered one-hot grant, or all-zero.
- `sel`  out  2: registered mux select, equal to the encoded index of `gnt`.
- `valid`  out  1: `y` holds a transferable word.
- `y`  out  WIDTH: selected data word when `valid` is high, otherwise all-zero.

## Operation
- States: IDLE and GRANT. Registered state: `gnt`, `sel`, round-robin pointer `ptr[1:0]`, transfer counter `cnt[3:0]`.
- **Arbitration.** Pick the first asserted `req` bit, scanning from `ptr` upward modulo 4. For example, with `ptr`=2 the scan order is 2, 3, 0, 1.
- **IDLE.** If `en`=1 and `req`≠0, load the winner into `gnt`/`sel`, clear `cnt` and go to GRANT. Otherwise stay in IDLE with `gnt`=0.
- **GRANT.**
  - `valid` is combinational: `en & req[sel]`.
  - `y` = data of input `sel` when `valid`=1, otherwise 0. No high-impedance output.
  - A transfer occurs on any cycle with `valid & ready`. Each transfer increments `cnt`.
- **Release conditions** (evaluated each GRANT cycle):
  - `req[sel]`=0, or
  - `en`=0, or
  - with `ARB_HOLD_LIMIT_EN`: a transfer occurs while `cnt`=`HOLD_MAX`-1.
- **On release:**
  - `ptr` ← `sel`+1 (mod 4).
  - If `en`=1 and some other `req` bit is set, re-arbitrate at the same edge using the new `ptr`. The released requester is excluded from that scan. The winner is loaded directly, with no IDLE bubble, and `cnt` clears.
  - Otherwise go to IDLE and clear `gnt`.
- A released requester that keeps `req` high competes again at its normal round-robin position.
- `req` dropping while `ready`=0 is legal. No transfer occurs for that word, and the grant is released.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `gnt`=0, `sel`=0, `ptr`=0, `cnt`=0, `valid`=0, `y`=0.
- Request-to-grant latency is 1 cycle: `req` sampled at edge N gives `gnt`/`sel` valid after edge N.
- `valid` and `y` follow `en`, `req` and the data inputs combinationally within the granted cycle.
- Requester handoff costs zero idle cycles when other requests are pending.
- Reset asserted mid-grant drops `gnt` and `valid` immediately. An in-flight word is not transferred.
- `en` deasserted mid-grant:
  - `valid` drops in the same cycle.
  - The grant is released at the next edge.
  - `ptr` advances.
- Requests appearing simultaneously with a release are eligible in that same release arbitration.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined:
  - Each grant ends after `HOLD_MAX` transfers, even if the requester's `req` is still high.
  - Provides starvation-free bounded latency: at most 3×`HOLD_MAX` transfers before a continuously requesting input is granted.
- `ARB_HOLD_LIMIT_EN` undefined:
  - `cnt` is not implemented.
  - A grant holds for as long as `req[sel]` and `en` stay high.
  - Rotation happens only on release.

## Test plan
- Reset: drive `rst`=1 with all `req`=1 → `gnt`=0, `valid`=0, `y`=0. After release, `en`=1 → `gnt`=0001 at the first edge.
- Rotation: `req`=1111 held, `ready`=1, macro on, `HOLD_MAX`=2.
  - Grants go 0001, 0010, 0100, 1000, 0001, 2 transfers each, with no idle cycles.
  - `y` = `a`, `b`, `c`, `d` in turn.
- Backpressure: single requester `b`=3'b101, `ready`=0 for 5 cycles.
  - `valid`=1 and `y`=101 stable throughout.
  - `cnt` stays 0.
  - The transfer counts only when `ready` rises.
- Request drop: grant on `c` with `req` falling to 0100→0001 → next edge `gnt`=0001, `ptr`=3.
- Enable: `en`=0 mid-grant on `d` → `valid`=0 at once, then `gnt`=0000 at the next edge. `en`=1 again with `req`=1001 → `gnt`=0001 (scan from `ptr`=0).
- Macro off: `req`=0011 held with `ready`=1 → `gnt` stays 0001 indefinitely. Dropping `req[0]` → `gnt`=0010 at the next edge.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4-to-1 data mux.
// Grants one requester at a time, steers the mux select, and presents the
// selected word downstream under a valid/ready handshake.
//
// Optional feature: define ARB_HOLD_LIMIT_EN to end every grant after
// HOLD_MAX transfers, giving bounded latency to every requester. Without it,
// a grant lasts as long as its request and the global enable stay high.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned HOLD_MAX = 4   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] y
);

  localparam logic StIdle  = 1'b0;
  localparam logic StGrant = 1'b1;

  logic       state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;

  logic       release_grant;
  logic       hold_done;
  logic [1:0] scan_ptr;
  logic [3:0] scan_req;
  logic       win_found;
  logic [1:0] win_idx;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [3:0] HoldLast = 4'(HOLD_MAX - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       xfer;

  assign xfer      = valid & ready;
  // Last permitted transfer of this grant is happening now.
  assign hold_done = xfer & (cnt_q == HoldLast);
`else
  // ready only matters downstream and HOLD_MAX only with the hold limit.
  logic unused_cfg;
  assign unused_cfg = ^{ready, 4'(HOLD_MAX)};
  assign hold_done  = 1'b0;
`endif

  // A live grant ends when its request drops, the block is disabled, or the
  // hold budget runs out.
  assign release_grant = (state_q == StGrant) & (~req[sel_q] | ~en | hold_done);

  // On release the scan starts just past the released requester and skips it;
  // otherwise scan from the stored pointer over all requests.
  always_comb begin
    scan_ptr = ptr_q;
    scan_req = req;
    if (release_grant) begin
      scan_ptr = sel_q + 2'd1;
      scan_req = req & ~(4'b0001 << sel_q);
    end
  end

  // Rotating priority pick: first set bit at or after scan_ptr, modulo 4.
  always_comb begin
    logic [1:0] idx;
    idx       = scan_ptr;
    win_found = 1'b0;
    win_idx   = scan_ptr;
    // Walk from the far end so the nearest candidate is written last.
    for (int k = 3; k >= 0; k--) begin
      idx = scan_ptr + 2'(k);
      if (scan_req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Next-state logic for the grant FSM, pointer and transfer counter.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (en && win_found) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
`ifdef ARB_HOLD_LIMIT_EN
          cnt_d   = 4'd0;
`endif
        end
      end
      StGrant: begin
        if (release_grant) begin
          ptr_d = sel_q + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
          cnt_d = 4'd0;
`endif
          if (en && win_found) begin
            // Hand straight over to the next requester, no idle bubble.
            gnt_d = 4'b0001 << win_idx;
            sel_d = win_idx;
          end else begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
          end
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Arbiter state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  // Transfers completed within the current grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = (state_q == StGrant) & en & req[sel_q];

  // Downstream word: the selected input while valid, zero otherwise.
  always_comb begin
    y = '0;
    if (valid) begin
      case (sel_q)
        2'd0:    y = a;
        2'd1:    y = b;
        2'd2:    y = c;
        default: y = d;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
// Honours ARB_HOLD_LIMIT_EN the same way the design does.
module tb_mux4_rr_arbiter;

  localparam int W    = 3;
  localparam int HOLD = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [3:0]   req;
  logic [W-1:0] a, b, c, d;
  logic         ready;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         valid;
  logic [W-1:0] y;

  int checks   = 0;
  int failures = 0;

  // Reference model: granted index (-1 when idle), pointer, transfer count.
  int m_g   = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(
    .WIDTH    (W),
    .HOLD_MAX (HOLD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .ready (ready),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .y     (y)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word(input int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  // First requesting index scanning up from p modulo 4, skipping excl.
  function automatic int pick(input logic [3:0] r, input int p, input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic compare_model();
    logic [3:0]   eg;
    logic         ev;
    logic [W-1:0] ey;
    eg = (m_g < 0) ? 4'b0000 : 4'(1 << m_g);
    ev = (m_g >= 0) && en && req[m_g];
    ey = ev ? word(m_g) : '0;
    chk("gnt", gnt, eg);
    if (m_g >= 0) chk("sel", sel, 32'(m_g));
    chk("valid", valid, ev);
    chk("y", y, ey);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    logic vld, xfer, rel;
    int   old;
    if (m_g < 0) begin
      if (en && req != 4'b0000) begin
        m_g   = pick(req, m_ptr, -1);
        m_cnt = 0;
      end
    end else begin
      vld  = en && req[m_g];
      xfer = vld && ready;
      rel  = !req[m_g] || !en;
`ifdef ARB_HOLD_LIMIT_EN
      if (xfer && m_cnt == HOLD - 1) rel = 1'b1;
`endif
      if (rel) begin
        old   = m_g;
        m_ptr = (old + 1) % 4;
        m_g   = en ? pick(req, m_ptr, old) : -1;
        m_cnt = 0;
      end else if (xfer) begin
        m_cnt++;
      end
    end
  endtask

  // One clock cycle: settle, compare, advance model, cross the edge.
  task automatic step();
    #1;
    compare_model();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset held through one edge; outputs must clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_y", y, '0);
    m_g   = -1;
    m_ptr = 0;
    m_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    req   = 4'b1111;
    ready = 1'b0;
    a     = 3'd1;
    b     = 3'd2;
    c     = 3'd3;
    d     = 3'd4;

    // Reset with every request high, then first grant goes to a.
    do_reset();
    step();
    chk("first_gnt", gnt, 4'b0001);
    // Reset mid-grant clears immediately (inside do_reset).
    do_reset();

    // Backpressure on a single requester.
    req = 4'b0010;
    b   = 3'b101;
    step();
    chk("bp_gnt", gnt, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", valid, 1'b1);
      chk("bp_y", y, 3'b101);
`ifdef ARB_HOLD_LIMIT_EN
      chk("bp_cnt", dut.cnt_q, 4'd0);
`endif
      step();
    end
    ready = 1'b1;
    step();
`ifdef ARB_HOLD_LIMIT_EN
    chk("bp_cnt_after", dut.cnt_q, 4'd1);
`endif
    ready = 1'b0;

    // Request drop: c releases, a is picked scanning from 3.
    do_reset();
    req = 4'b0100;
    step();
    chk("drop_gnt_c", gnt, 4'b0100);
    req = 4'b0001;
    step();
    chk("drop_gnt_a", gnt, 4'b0001);
    chk("drop_ptr", dut.ptr_q, 2'd3);

    // Enable dropped mid-grant on d.
    do_reset();
    req = 4'b1000;
    step();
    chk("en_gnt_d", gnt, 4'b1000);
    en = 1'b0;
    #1;
    chk("en_valid_drop", valid, 1'b0);
    step();
    chk("en_gnt_clear", gnt, 4'b0000);
    en  = 1'b1;
    req = 4'b1001;
    step();
    chk("en_regrant", gnt, 4'b0001);

`ifdef ARB_HOLD_LIMIT_EN
    // Rotation with the hold limit: two transfers per requester.
    do_reset();
    begin
      int exp_i [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      a     = 3'd1;
      b     = 3'd2;
      c     = 3'd3;
      d     = 3'd4;
      req   = 4'b1111;
      ready = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
        #1;
        chk("rot_gnt", gnt, 4'(1 << exp_i[i]));
        chk("rot_y", y, 3'(exp_i[i] + 1));
        step();
      end
    end
`else
    // Without the hold limit a grant persists while its request does.
    do_reset();
    req   = 4'b0011;
    ready = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      chk("hold_gnt", gnt, 4'b0001);
      step();
    end
    req = 4'b0010;
    step();
    chk("hold_handoff", gnt, 4'b0010);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      end
      en    = ($urandom_range(0, 19) != 0);
      ready = ($urandom_range(0, 9) < 6);
      a     = W'($urandom);
      b     = W'($urandom);
      c     = W'($urandom);
      d     = W'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
